clk_div_gen: RTL and testbench
==============================

// Module: clk_div_gen
// PURPOSE
//   Programmable clock divider/enable generator fed by the system clock (clk).
//   Produces a registered divided clock (clk_out) plus 1-cycle rise/fall tick
//   strobes for slower domains (e.g. 100 MHz -> 25 MHz with divisor 4).
//   Divisor is reprogrammable at run time; changes take effect only on a period
//   boundary, so clk_out never glitches. Start/stop is graceful.
// PARAMETERS
//   CNT_W      16  width of divisor and phase counter
//   DIV_RESET   4  divisor loaded at reset; must be >= 2
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   rst        in   1      asynchronous, active-low reset (0 = reset)
//   en         in   1      run request; sampled each edge
//   div_load   in   1      1-cycle strobe: capture div_val
//   div_val    in   CNT_W  requested divisor N
//   div_ack    out  1      1-cycle pulse: pending divisor now in use
//   div_err    out  1      1-cycle pulse: div_val < 2 rejected
//   div_cur    out  CNT_W  divisor currently in use
//   clk_out    out  1      divided clock, registered
//   rise_tick  out  1      1-cycle pulse on edge clk_out goes 0->1
//   fall_tick  out  1      1-cycle pulse on edge clk_out goes 1->0
//   running    out  1      1 in RUN or DRAIN
//   period_cnt out  8      completed full periods, wraps 255->0
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, cnt=0, clk_out=0, all ticks/acks/err=0,
//     div_cur=DIV_RESET, pend=0, running=0, period_cnt=0. Reset mid-period
//     aborts immediately; no trailing tick.
//   Phase split for N: L = N>>1 (low cycles), H = N-L (high cycles); N=3 -> H2/L1.
//   States: IDLE, RUN, DRAIN.
//   IDLE: clk_out=0. Pending divisor applied on next edge (div_ack pulses).
//     en=1 -> RUN: cnt<=0, clk_out<=1, rise_tick<=1 (uses div_cur after apply).
//   RUN, each edge:
//     cnt==N-1 (wrap): cnt<=0, period_cnt++; if pend: div_cur<=pending,
//       pend<=0, div_ack<=1. If en=1: clk_out<=1, rise_tick<=1; else -> IDLE.
//     else cnt<=cnt+1; if cnt+1==H: clk_out<=0, fall_tick<=1.
//     en=0 while cnt != N-1 -> DRAIN (period completes unchanged).
//   DRAIN: counts like RUN; at wrap -> IDLE with clk_out=0, no rise_tick.
//     en=1 again in DRAIN -> back to RUN, no phase disturbance.
//   div_load: div_val<2 -> div_err<=1, nothing else changes. Else pending<=
//     div_val, pend<=1; later load before apply overwrites (last wins).
//   div_load on the same edge as a wrap: the wrap applies the older pending
//     value (if any); the new value becomes pending for the next boundary.
//   Ticks, div_ack, div_err are single-cycle, registered; never stretched.
//   Latency: rise_tick/fall_tick coincide with the clk_out transition edge.
// TESTING
//   1 Reset, en=1, N=4 -> clk_out 1100 repeating, rise every 4 clks, fall 2
//     clks after rise; period_cnt=3 after 12 clks.
//   2 N=3 and N=2 -> high/low = 2/1 and 1/1; tick spacing matches.
//   3 div_load 8 mid-period at N=4 -> current period stays 4 clks, div_ack at
//     wrap, next period 8 clks (4 high/4 low); div_cur=8.
//   4 div_load 1 and 0 -> div_err pulse each, div_cur unchanged, no div_ack.
//   5 en drop at cnt=1 (N=4) -> clk_out completes 1,0,0 then stays 0, running
//     falls at wrap; en=1 during DRAIN keeps clocking seamlessly.
//   6 rst=0 asserted mid-high phase -> clk_out=0, running=0 immediately
//     (async, no clk edge); period_cnt=0; 255 periods then 1 more -> wraps to 0.

Source files
------------

// File: rtl/clk_div_gen.sv
// Programmable clock divider / enable generator.
// Produces a registered divided clock plus single-cycle rise/fall strobes.
// The divisor can be reprogrammed at any time. A new divisor only takes effect
// on a period boundary, or while idle, so clk_out never glitches.
// Start/stop is graceful: dropping en lets the current period finish.
module clk_div_gen #(
   parameter int CNT_W     = 16,
   parameter int DIV_RESET = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_load,
   input  logic [CNT_W-1:0] div_val,
   output logic             div_ack,
   output logic             div_err,
   output logic [CNT_W-1:0] div_cur,
   output logic             clk_out,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic             running,
   output logic [7:0]       period_cnt
);

   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);
   localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] pending, pending_nxt;
   logic             pend, pend_nxt;
   logic [CNT_W-1:0] div_cur_nxt;
   logic             clk_out_nxt;
   logic             rise_nxt, fall_nxt;
   logic             ack_nxt, err_nxt;
   logic [7:0]       period_nxt;

   // Derived phase quantities for the divisor in use.
   // The high phase gets the extra cycle of an odd divisor: N=3 gives 2 high, 1 low.
   logic [CNT_W-1:0] last_cnt;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] cnt_inc;
   logic             wrap;
   logic             apply;

   assign last_cnt = div_cur - CNT_W'(1);
   assign high_len = div_cur - (div_cur >> 1);
   assign cnt_inc  = cnt + CNT_W'(1);
   assign wrap     = (cnt == last_cnt);

   // running covers both clocking states, so it drops only after the final period.
   assign running  = (state != S_IDLE);

   // Next-state and next-output logic for the run/drain sequencer and divisor update.
   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
      state_nxt   = state;
      cnt_nxt     = cnt;
      clk_out_nxt = clk_out;
      rise_nxt    = 1'b0;
      fall_nxt    = 1'b0;
      ack_nxt     = 1'b0;
      err_nxt     = 1'b0;
      div_cur_nxt = div_cur;
      pend_nxt    = pend;
      pending_nxt = pending;
      period_nxt  = period_cnt;
      apply       = 1'b0;

      unique case (state)
         S_IDLE: begin
            clk_out_nxt = 1'b0;
            apply       = pend;
            if (en) begin
               state_nxt   = S_RUN;
               cnt_nxt     = '0;
               clk_out_nxt = 1'b1;
               rise_nxt    = 1'b1;
            end
         end

         S_RUN, S_DRAIN: begin
            if (wrap) begin
               // A period boundary is the only safe point to switch divisors.
               cnt_nxt    = '0;
               period_nxt = period_cnt + 8'd1;
               apply      = pend;
               if (en) begin
                  state_nxt   = S_RUN;
                  clk_out_nxt = 1'b1;
                  rise_nxt    = 1'b1;
               end else begin
                  state_nxt   = S_IDLE;
                  clk_out_nxt = 1'b0;
               end
            end else begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == high_len) begin
                  clk_out_nxt = 1'b0;
                  fall_nxt    = 1'b1;
               end
               // Dropping en mid-period only marks the drain.
               // The period still completes with its phase intact.
               state_nxt = en ? S_RUN : S_DRAIN;
            end
         end

         default: begin
            state_nxt   = S_IDLE;
            cnt_nxt     = '0;
            clk_out_nxt = 1'b0;
         end
      endcase

      // Install the previously pending divisor.
      if (apply) begin
         div_cur_nxt = pending;
         pend_nxt    = 1'b0;
         ack_nxt     = 1'b1;
      end

      // A load on the same edge as an apply waits for the next boundary.
      // Evaluating it after the apply gives that ordering, and last-wins for repeated loads.
      if (div_load) begin
         if (div_val < DIV_MIN) begin
            err_nxt = 1'b1;
         end else begin
            pending_nxt = div_val;
            pend_nxt    = 1'b1;
         end
      end
   end

   // State and output registers; reset aborts any period at once with no trailing tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         clk_out    <= 1'b0;
         rise_tick  <= 1'b0;
         fall_tick  <= 1'b0;
         div_ack    <= 1'b0;
         div_err    <= 1'b0;
         div_cur    <= DIV_INIT;
         pending    <= DIV_INIT;
         pend       <= 1'b0;
         period_cnt <= 8'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         clk_out    <= clk_out_nxt;
         rise_tick  <= rise_nxt;
         fall_tick  <= fall_nxt;
         div_ack    <= ack_nxt;
         div_err    <= err_nxt;
         div_cur    <= div_cur_nxt;
         pending    <= pending_nxt;
         pend       <= pend_nxt;
         period_cnt <= period_nxt;
      end
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen.
// Edge numbers in the comments count rising clk edges after reset release.
module tb_clk_div_gen;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             div_load;
   logic [CNT_W-1:0] div_val;
   logic             div_ack;
   logic             div_err;
   logic [CNT_W-1:0] div_cur;
   logic             clk_out;
   logic             rise_tick;
   logic             fall_tick;
   logic             running;
   logic [7:0]       period_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   clk_div_gen #(.CNT_W(CNT_W), .DIV_RESET(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .div_load  (div_load),
      .div_val   (div_val),
      .div_ack   (div_ack),
      .div_err   (div_err),
      .div_cur   (div_cur),
      .clk_out   (clk_out),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .running   (running),
      .period_cnt(period_cnt)
   );

   // 10-unit system clock.
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 unit so outputs are sampled away from the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Phase-pattern check for one sample: p is the cycle index within the period (0 = rise cycle).
   task automatic chk_phase(input string tag, input int p, input int h);
      chk({tag, "_clk"},  {31'd0, clk_out},   {31'd0, (p < h)});
      chk({tag, "_rise"}, {31'd0, rise_tick}, {31'd0, (p == 0)});
      chk({tag, "_fall"}, {31'd0, fall_tick}, {31'd0, (p == h)});
      chk({tag, "_ack"},  {31'd0, div_ack},   32'd0);
   endtask

   // Watchdog so the bench always ends on its own.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b0;
      en       = 1'b0;
      div_load = 1'b0;
      div_val  = '0;

      // Reset state, with clocks running while reset is held.
      step(2);
      chk("rst_clk_out", {31'd0, clk_out}, 32'd0);
      chk("rst_running", {31'd0, running}, 32'd0);
      chk("rst_div_cur", {16'd0, div_cur}, 32'd4);
      chk("rst_period",  {24'd0, period_cnt}, 32'd0);
      chk("rst_rise",    {31'd0, rise_tick}, 32'd0);
      chk("rst_ack",     {31'd0, div_ack}, 32'd0);
      chk("rst_err",     {31'd0, div_err}, 32'd0);
      rst = 1'b1;

      // Test 1: N=4 gives 1100 repeating. Edge 1 is the start; wraps at edges 5, 9, 13.
      en = 1'b1;
      for (int i = 0; i < 13; i++) begin
         step(1);
         chk_phase($sformatf("n4[%0d]", i), i % 4, 2);
         chk($sformatf("n4_run[%0d]", i), {31'd0, running}, 32'd1);
      end
      chk("n4_period", {24'd0, period_cnt}, 32'd3);

      // Test 2a: switch to N=3. Load at edge 14 (cnt 0->1); the apply comes at wrap edge 17.
      div_load = 1'b1; div_val = 16'd3;
      step(1);
      div_load = 1'b0;
      chk("n3_no_early_ack", {31'd0, div_ack}, 32'd0);
      chk("n3_cur_before",   {16'd0, div_cur}, 32'd4);
      step(3);
      chk("n3_ack",    {31'd0, div_ack}, 32'd1);
      chk("n3_cur",    {16'd0, div_cur}, 32'd3);
      chk("n3_rise",   {31'd0, rise_tick}, 32'd1);
      chk("n3_period", {24'd0, period_cnt}, 32'd4);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         chk_phase($sformatf("n3[%0d]", k), k % 3, 2);
      end

      // Test 2b: switch to N=2. Load at edge 24; edge 25 falls; the apply comes at wrap edge 26.
      div_load = 1'b1; div_val = 16'd2;
      step(1);
      div_load = 1'b0;
      step(2);
      chk("n2_ack",  {31'd0, div_ack}, 32'd1);
      chk("n2_cur",  {16'd0, div_cur}, 32'd2);
      chk("n2_rise", {31'd0, rise_tick}, 32'd1);
      for (int k = 1; k <= 4; k++) begin
         step(1);
         chk_phase($sformatf("n2[%0d]", k), k % 2, 1);
      end
      chk("n2_period", {24'd0, period_cnt}, 32'd9);

      // Test 3: return to N=4 (load at edge 31, apply at edge 32).
      div_load = 1'b1; div_val = 16'd4;
      step(1);
      div_load = 1'b0;
      step(1);
      chk("n4b_ack", {31'd0, div_ack}, 32'd1);
      chk("n4b_cur", {16'd0, div_cur}, 32'd4);
      // Load 8 mid-period at edge 34. The current period still ends at edge 36.
      step(1);
      div_load = 1'b1; div_val = 16'd8;
      step(1);
      div_load = 1'b0;
      chk("n8_mid_fall", {31'd0, fall_tick}, 32'd1);
      chk("n8_mid_ack",  {31'd0, div_ack}, 32'd0);
      chk("n8_mid_cur",  {16'd0, div_cur}, 32'd4);
      step(1);
      chk("n8_pre_wrap_clk", {31'd0, clk_out}, 32'd0);
      step(1);
      chk("n8_ack",  {31'd0, div_ack}, 32'd1);
      chk("n8_rise", {31'd0, rise_tick}, 32'd1);
      chk("n8_cur",  {16'd0, div_cur}, 32'd8);
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk_phase($sformatf("n8[%0d]", k), k % 8, 4);
      end
      chk("n8_period", {24'd0, period_cnt}, 32'd12);

      // Test 3b: load 6 at edge 45, then load 4 on wrap edge 52.
      // The wrap applies 6; 4 waits for the next boundary (edge 58).
      div_load = 1'b1; div_val = 16'd6;
      step(1);
      div_load = 1'b0;
      step(6);
      div_load = 1'b1; div_val = 16'd4;
      step(1);
      div_load = 1'b0;
      chk("same_edge_ack",  {31'd0, div_ack}, 32'd1);
      chk("same_edge_cur",  {16'd0, div_cur}, 32'd6);
      chk("same_edge_rise", {31'd0, rise_tick}, 32'd1);
      step(3);
      chk("n6_fall", {31'd0, fall_tick}, 32'd1);
      step(2);
      chk("n6_last_clk", {31'd0, clk_out}, 32'd0);
      chk("n6_last_ack", {31'd0, div_ack}, 32'd0);
      chk("n6_last_cur", {16'd0, div_cur}, 32'd6);
      step(1);
      chk("n4c_ack",    {31'd0, div_ack}, 32'd1);
      chk("n4c_cur",    {16'd0, div_cur}, 32'd4);
      chk("n4c_period", {24'd0, period_cnt}, 32'd14);

      // Test 4: illegal divisors 1 and 0 are rejected with an error pulse only.
      div_load = 1'b1; div_val = 16'd1;
      step(1);
      div_load = 1'b0;
      chk("err1_pulse", {31'd0, div_err}, 32'd1);
      chk("err1_cur",   {16'd0, div_cur}, 32'd4);
      step(1);
      chk("err1_clear", {31'd0, div_err}, 32'd0);
      div_load = 1'b1; div_val = 16'd0;
      step(1);
      div_load = 1'b0;
      chk("err0_pulse", {31'd0, div_err}, 32'd1);
      step(1);
      chk("err0_clear",   {31'd0, div_err}, 32'd0);
      chk("err_no_ack",   {31'd0, div_ack}, 32'd0);
      chk("err_wrap_rise", {31'd0, rise_tick}, 32'd1);
      chk("err_cur",      {16'd0, div_cur}, 32'd4);

      // Test 5: drop en at cnt=1 (edge 63). The period completes 1,0,0 and then idles at edge 66.
      step(1);
      en = 1'b0;
      step(1);
      chk("drain_clk_a",  {31'd0, clk_out}, 32'd0);
      chk("drain_fall",   {31'd0, fall_tick}, 32'd1);
      chk("drain_run_a",  {31'd0, running}, 32'd1);
      step(1);
      chk("drain_clk_b",  {31'd0, clk_out}, 32'd0);
      chk("drain_run_b",  {31'd0, running}, 32'd1);
      step(1);
      chk("drain_end_run",  {31'd0, running}, 32'd0);
      chk("drain_end_clk",  {31'd0, clk_out}, 32'd0);
      chk("drain_end_rise", {31'd0, rise_tick}, 32'd0);
      chk("drain_period",   {24'd0, period_cnt}, 32'd16);
      step(1);
      chk("idle_clk", {31'd0, clk_out}, 32'd0);
      chk("idle_run", {31'd0, running}, 32'd0);
      // Restart at edge 68, drop en for the high-to-low edge, then raise it again during the drain.
      en = 1'b1;
      step(1);
      chk("restart_rise", {31'd0, rise_tick}, 32'd1);
      step(1);
      en = 1'b0;
      step(1);
      chk("redrain_fall", {31'd0, fall_tick}, 32'd1);
      en = 1'b1;
      step(1);
      chk("resume_run", {31'd0, running}, 32'd1);
      chk("resume_clk", {31'd0, clk_out}, 32'd0);
      step(1);
      chk("resume_rise",   {31'd0, rise_tick}, 32'd1);
      chk("resume_clkhi",  {31'd0, clk_out}, 32'd1);
      chk("resume_period", {24'd0, period_cnt}, 32'd17);

      // Test 6: asynchronous reset mid-high phase, applied between clock edges.
      #1;
      rst = 1'b0;
      #1;
      chk("async_clk",    {31'd0, clk_out}, 32'd0);
      chk("async_run",    {31'd0, running}, 32'd0);
      chk("async_period", {24'd0, period_cnt}, 32'd0);
      chk("async_rise",   {31'd0, rise_tick}, 32'd0);
      chk("async_cur",    {16'd0, div_cur}, 32'd4);
      en = 1'b0;
      step(1);
      rst = 1'b1;

      // In idle: load 2, and the next edge applies it.
      div_load = 1'b1; div_val = 16'd2;
      step(1);
      div_load = 1'b0;
      chk("idle_load_no_ack", {31'd0, div_ack}, 32'd0);
      step(1);
      chk("idle_apply_ack", {31'd0, div_ack}, 32'd1);
      chk("idle_apply_cur", {16'd0, div_cur}, 32'd2);
      chk("idle_apply_run", {31'd0, running}, 32'd0);

      // With N=2 a period wraps every 2 edges. After 255 periods the count is 255; one more wraps it to 0.
      en = 1'b1;
      step(1);
      chk("wrap_start_rise", {31'd0, rise_tick}, 32'd1);
      step(2 * 255);
      chk("period_255", {24'd0, period_cnt}, 32'd255);
      step(2);
      chk("period_wrap", {24'd0, period_cnt}, 32'd0);
      chk("period_wrap_rise", {31'd0, rise_tick}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
